// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings and register map for the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge-side register bus plus interrupt line
interface timer_counter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer driving one CP0 interrupt bit
module timer_counter
  import timer_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;
  logic              r_irq_pending;

  logic [DATA_W-1:0] w_count_nxt;
  logic              w_pend_set;
  logic              w_pend_clr_fsm;
  logic              w_en_clr;
  logic              w_wr_ctrl;
  logic              w_wr_preset;
  ctrl_t             w_ctrl_wr;
  logic [DATA_W-1:0] w_rdata;

  assign w_wr_ctrl   = bus.we && (bus.addr == ADDR_W'(REG_CTRL));
  assign w_wr_preset = bus.we && (bus.addr == ADDR_W'(REG_PRESET));

  assign w_ctrl_wr.im   = bus.wdata[CTRL_IM_BIT];
  assign w_ctrl_wr.mode = bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign w_ctrl_wr.en   = bus.wdata[CTRL_EN_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // COUNT stops at zero on expiry, so a PRESET of 0 expires like a PRESET of 1
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_pend_set     = 1'b0;
    w_pend_clr_fsm = 1'b0;
    w_en_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl.en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > DATA_W'(1)) begin
          w_count_nxt = r_count - DATA_W'(1);
        end else begin
          w_count_nxt = '0;
          w_pend_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (r_ctrl.mode == MODE_PERIODIC) begin
          w_pend_clr_fsm = 1'b1;
        end else begin
          w_en_clr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A software CTRL write overrides the one-shot enable clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl        <= '0;
      r_preset      <= '0;
      r_count       <= '0;
      r_irq_pending <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_wr;
      end else if (w_en_clr) begin
        r_ctrl.en <= 1'b0;
      end
      if (w_wr_preset) begin
        r_preset <= bus.wdata;
      end
      if (w_pend_set) begin
        r_irq_pending <= 1'b1;
      end else if (w_pend_clr_fsm || w_wr_ctrl || w_wr_preset) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      ADDR_W'(REG_CTRL):   w_rdata = DATA_W'(r_ctrl);
      ADDR_W'(REG_PRESET): w_rdata = r_preset;
      ADDR_W'(REG_COUNT):  w_rdata = r_count;
      ADDR_W'(REG_RSVD):   w_rdata = '0;
      default:             w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign bus.irq   = r_ctrl.im & r_irq_pending;

endmodule
